// File: rtl/banked_mem_port.sv
// -----------------------------------------------------------------------------
// banked_mem_port
//   Single-ported memory built from NUM_LANES byte-wide banks. Requests and
//   responses both use valid/ready handshakes. Accesses of 1/2/4/8 bytes are
//   supported. A misaligned access spills into the next row: lanes below the
//   byte offset address row+1, which wraps modulo DEPTH. Loads are sign- or
//   zero-extended. Illegal sizes return an error and write nothing. After
//   reset, an optional sweep writes zero to every row before the first request
//   is accepted.
//
//   Compile-time option:
//     MISALIGN_TRAP_EN - when defined, any access whose address is not a
//                        multiple of its size gets an error response, and no
//                        lanes are written.
//
//   Ports:
//     clk, rst_n       clock; asynchronous active-low reset
//     req_valid/ready  request handshake
//     req_we           1 = store, 0 = load
//     req_size         access is 2^req_size bytes
//     req_unsigned     1 = zero-extend loads, 0 = sign-extend loads
//     req_addr         byte address; bits above offset+row are ignored
//     req_wdata        store data, LSB-aligned
//     rsp_valid/ready  response handshake
//     rsp_rdata        extended load data; 0 for stores and errors
//     rsp_err          request was illegal
//     clear_done       high once the clear sweep has finished
// -----------------------------------------------------------------------------
module banked_mem_port #(
  parameter int NUM_LANES      = 4,
  parameter int DEPTH          = 2048,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [8*NUM_LANES-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*NUM_LANES-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   clear_done
);

  localparam int DW = 8 * NUM_LANES;
  localparam int LW = $clog2(NUM_LANES);
  localparam int RW = $clog2(DEPTH);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t              state_r, state_nxt_s;
  logic [RW-1:0]       clr_cnt_r;
  logic                clear_active_s;
  logic                clear_done_r;

  logic                rsp_valid_r, rsp_err_r, rsp_we_r, rsp_uns_r;
  logic [1:0]          rsp_size_r;
  logic [LW-1:0]       rsp_off_r;

  logic                req_ready_s, accept_s;
  logic [LW-1:0]       req_off_s;
  logic [RW-1:0]       req_row_s, req_row_p1_s;
  logic                size_legal_s, misalign_s, req_err_s;
  logic [LW:0]         req_bytes_s;
  logic [NUM_LANES-1:0] lane_mask_s, ram_en_s, ram_we_s;
  logic [DW-1:0]       ram_wdata_s, rd_data_s, rdata_s;
  logic [NUM_LANES*RW-1:0] ram_addr_s;

  // Clear/run sequencing: leave CLEAR after the last row has been written.
  always_comb begin
    state_nxt_s    = state_r;
    clear_active_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clear_active_s = 1'b1;
        if (clr_cnt_r == RW'(DEPTH - 1)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = RST_STATE;
    endcase
  end

  // State register, sweep row counter and clear_done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RST_STATE;
      clr_cnt_r    <= '0;
      clear_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      clear_done_r <= (state_nxt_s == ST_RUN);
      if (clear_active_s) begin
        clr_cnt_r <= clr_cnt_r + RW'(1);
      end else begin
        clr_cnt_r <= clr_cnt_r;
      end
    end
  end

  // clear_done implies RUN; a held response blocks new requests.
  assign req_ready_s = clear_done_r && (!rsp_valid_r || rsp_ready);
  assign accept_s    = req_valid && req_ready_s;

  // Request decode: address split, legality checks and lane byte-enables.
  always_comb begin
    req_off_s    = req_addr[LW-1:0];
    req_row_s    = req_addr[LW +: RW];
    req_row_p1_s = req_row_s + RW'(1);
    size_legal_s = (int'(req_size) <= LW);
    if (size_legal_s) begin
      req_bytes_s = (LW+1)'(1) << req_size;
    end else begin
      req_bytes_s = '0;
    end
`ifdef MISALIGN_TRAP_EN
    misalign_s = |({1'b0, req_off_s} & (req_bytes_s - (LW+1)'(1)));
`else
    misalign_s = 1'b0;
`endif
    req_err_s = !size_legal_s || misalign_s;
  end

  // Per-lane RAM controls. The sweep has priority. Otherwise, lanes below the
  // offset take row+1, and store bytes are rotated left by the offset.
  always_comb begin
    logic [LW-1:0] rel;
    lane_mask_s = '0;
    ram_en_s    = '0;
    ram_we_s    = '0;
    ram_wdata_s = '0;
    ram_addr_s  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rel            = LW'(i) - req_off_s;
      lane_mask_s[i] = ({1'b0, rel} < req_bytes_s);
      if (clear_active_s) begin
        ram_en_s[i]                = 1'b1;
        ram_we_s[i]                = 1'b1;
        ram_wdata_s[8*i +: 8]      = 8'h00;
        ram_addr_s[RW*i +: RW]     = clr_cnt_r;
      end else begin
        ram_en_s[i]                = accept_s;
        ram_we_s[i]                = accept_s && req_we && !req_err_s && lane_mask_s[i];
        ram_wdata_s[8*i +: 8]      = req_wdata[8*int'(rel) +: 8];
        if (LW'(i) < req_off_s) begin
          ram_addr_s[RW*i +: RW] = req_row_p1_s;
        end else begin
          ram_addr_s[RW*i +: RW] = req_row_s;
        end
      end
    end
  end

  // Byte-wide synchronous-read banks; contents are deliberately not reset.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] mem_r [DEPTH];
    logic [7:0] rd_byte_r;

    // One bank: write when enabled and selected; read register updates on every enable.
    always_ff @(posedge clk) begin
      if (ram_en_s[gi]) begin
        if (ram_we_s[gi]) begin
          mem_r[ram_addr_s[RW*gi +: RW]] <= ram_wdata_s[8*gi +: 8];
        end
        rd_byte_r <= mem_r[ram_addr_s[RW*gi +: RW]];
      end
    end

    assign rd_data_s[8*gi +: 8] = rd_byte_r;
  end

  // Response state: capture request attributes at acceptance and hold them while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_uns_r   <= 1'b0;
      rsp_size_r  <= 2'd0;
      rsp_off_r   <= '0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= req_err_s;
      rsp_we_r    <= req_we;
      rsp_uns_r   <= req_unsigned;
      rsp_size_r  <= req_size;
      rsp_off_r   <= req_off_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  // Load data path: rotate right by the offset, truncate to the access size, then extend.
  always_comb begin
    logic [DW-1:0] rot;
    logic [LW-1:0] src;
    logic [LW:0]   bytes;
    logic          sign;
    rot     = '0;
    src     = '0;
    sign    = 1'b0;
    rdata_s = '0;
    bytes   = (LW+1)'(1) << rsp_size_r;
    for (int j = 0; j < NUM_LANES; j++) begin
      src            = LW'(j) + rsp_off_r;
      rot[8*j +: 8]  = rd_data_s[8*int'(src) +: 8];
    end
    for (int j = 0; j < NUM_LANES; j++) begin
      if ((LW+1)'(j) == bytes - (LW+1)'(1)) begin
        sign = rot[8*j+7];
      end else begin
        sign = sign;
      end
    end
    for (int j = 0; j < NUM_LANES; j++) begin
      if ((LW+1)'(j) < bytes) begin
        rdata_s[8*j +: 8] = rot[8*j +: 8];
      end else begin
        rdata_s[8*j +: 8] = {8{sign && !rsp_uns_r}};
      end
    end
    if (!rsp_valid_r || rsp_err_r || rsp_we_r) begin
      rdata_s = '0;
    end else begin
      rdata_s = rdata_s;
    end
  end

  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_err    = rsp_err_r;
  assign rsp_rdata  = rdata_s;
  assign clear_done = clear_done_r;

endmodule

// File: tb/tb_banked_mem_port.sv
module tb_banked_mem_port;

  localparam int NL = 4;
  localparam int DP = 16;
  localparam int AW = 32;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, clear_done;
  logic [31:0] rsp_rdata;

  banked_mem_port #(.NUM_LANES(NL), .DEPTH(DP), .ADDR_W(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   stamps_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pop and compare each response as it is consumed.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b, expected no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        stamps_q.push_back(cyc);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.rdata      = exp_rd;
    e.err        = exp_err;
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept: req_ready=0 after 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  task automatic check_sweep();
    chk("sweep_start", {30'd0, clear_done, req_ready}, 32'd0);
    for (int k = 1; k <= DP; k++) begin
      @(posedge clk);
      #1;
      chk("sweep", {30'd0, clear_done, req_ready}, (k == DP) ? 32'd3 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected to finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {28'd0, req_ready, rsp_valid, rsp_err, clear_done}, 32'd0);
    rst_n = 1'b1;
    check_sweep();

    // Cleared memory reads back as zero.
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    drain();

    // Misaligned store spanning row 1 and row 2.
    do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hAABBCCDD, 32'h0, TRAP);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, TRAP ? 32'h0 : 32'hCCDD0000, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, TRAP ? 32'h0 : 32'h0000AABB, 1'b0);
    drain();

    // Store followed directly by loads; check extension.
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223380, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, 32'h00000080, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 32'h00001122, 1'b0);
    drain();

    // Row wrap: last row spills into row 0.
    do_req(1'b1, 2'd2, 1'b0, 32'h3E, 32'h01020304, 32'h0, TRAP);
    do_req(1'b0, 2'd1, 1'b1, 32'h3E, 32'h0, TRAP ? 32'h0 : 32'h0304, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, TRAP ? 32'h0 : 32'h0102, 1'b0);
    drain();

    // Backpressure: the response holds for 3 cycles.
    rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h11223380, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, 32'h11223380);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    // Streaming: 4 back-to-back loads, one response per cycle.
    stamps_q.delete();
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h11223380, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, TRAP ? 32'h0 : 32'hCCDD0000, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, TRAP ? 32'h0 : 32'h0102, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, TRAP ? 32'h0 : 32'h03040000, 1'b0);
    drain();
    chk("stream_count", stamps_q.size(), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < stamps_q.size()) begin
        chk("stream_gap", stamps_q[i] - stamps_q[i-1], 32'd1);
      end else begin
        chk("stream_missing", i, stamps_q.size());
      end
    end

    // Oversize access is an error.
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    drain();

    // Reset mid-response: the response drops at once and the sweep repeats.
    rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h11223380, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_drop", {29'd0, rsp_valid, req_ready, clear_done}, 32'd0);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_sweep();
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
